// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit driving a word-addressed dmem port; LSU_MISALIGNED_EN enables
// in-word misaligned and word-crossing (two-beat) accesses, otherwise misaligned requests fault.
module lsu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             rsp_misaligned,
  output logic             mem_read,
  output logic             mem_write,
  output logic [WIDTH-3:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [3:0]       mem_byteen,
  input  logic [WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  state_t     state;
  logic       we_q;
  logic [2:0] f3_q;
  logic [1:0] off_q;
  logic [1:0] req_off;
  logic [2:0] req_n;

  // {hi,lo} is shifted down by the byte offset, then trimmed and extended to the access size.
  function automatic logic [WIDTH-1:0] extend(input logic [2*WIDTH-1:0] pair,
                                              input logic [1:0] off, input logic [2:0] f3);
    logic [WIDTH-1:0] s;
    s = WIDTH'(pair >> {off, 3'b000});
    case (f3[1:0])
      2'b00:   extend = {{(WIDTH-8){~f3[2] & s[7]}}, s[7:0]};
      2'b01:   extend = {{(WIDTH-16){~f3[2] & s[15]}}, s[15:0]};
      default: extend = s;
    endcase
  endfunction

  assign req_off   = req_addr[1:0];
  assign req_ready = rst_n && (state == IDLE);

  always_comb begin
    case (req_funct3[1:0])
      2'b00:   req_n = 3'd1;
      2'b01:   req_n = 3'd2;
      default: req_n = 3'd4;
    endcase
  end

`ifdef LSU_MISALIGNED_EN
  logic [7:0]         be_mask;
  logic [2*WIDTH-1:0] wdata_sh;
  logic               req_cross;
  logic               cross_q;
  logic [WIDTH-3:0]   addr_hi_q;
  logic [WIDTH-1:0]   wdata_hi_q;
  logic [3:0]         be_hi_q;
  logic [WIDTH-1:0]   lo_q;

  // Upper halves of the mask and shifted data are exactly the second-beat lanes.
  assign be_mask   = ((8'd1 << req_n) - 8'd1) << req_off;
  assign wdata_sh  = {{WIDTH{1'b0}}, req_wdata} << {req_off, 3'b000};
  assign req_cross = ({1'b0, req_off} + req_n) > 3'd4;
`else
  logic [3:0]       be_mask;
  logic [WIDTH-1:0] wdata_sh;
  logic             req_misal;

  assign be_mask   = ((4'd1 << req_n) - 4'd1) << req_off;
  assign wdata_sh  = req_wdata << {req_off, 3'b000};
  assign req_misal = ((req_funct3[1:0] == 2'b01) && req_off[0]) ||
                     (req_funct3[1] && (req_off != 2'b00));
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      we_q           <= 1'b0;
      f3_q           <= 3'd0;
      off_q          <= 2'd0;
      rsp_valid      <= 1'b0;
      rsp_rdata      <= '0;
      rsp_misaligned <= 1'b0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_byteen     <= 4'd0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q  <= req_we;
            f3_q  <= req_funct3;
            off_q <= req_off;
`ifdef LSU_MISALIGNED_EN
            state      <= BEAT0;
            mem_read   <= !req_we;
            mem_write  <= req_we;
            mem_addr   <= req_addr[WIDTH-1:2];
            mem_wdata  <= wdata_sh[WIDTH-1:0];
            mem_byteen <= be_mask[3:0];
            cross_q    <= req_cross;
            addr_hi_q  <= req_addr[WIDTH-1:2] + (WIDTH-2)'(1);
            wdata_hi_q <= wdata_sh[2*WIDTH-1:WIDTH];
            be_hi_q    <= be_mask[7:4];
`else
            if (req_misal) begin
              state          <= RESP;
              rsp_valid      <= 1'b1;
              rsp_misaligned <= 1'b1;
              rsp_rdata      <= '0;
            end else begin
              state      <= BEAT0;
              mem_read   <= !req_we;
              mem_write  <= req_we;
              mem_addr   <= req_addr[WIDTH-1:2];
              mem_wdata  <= wdata_sh;
              mem_byteen <= be_mask;
            end
`endif
          end
        end
        BEAT0: begin
`ifdef LSU_MISALIGNED_EN
          if (cross_q) begin
            state      <= BEAT1;
            mem_addr   <= addr_hi_q;
            mem_wdata  <= wdata_hi_q;
            mem_byteen <= be_hi_q;
            lo_q       <= mem_rdata;
          end else
`endif
          begin
            state      <= RESP;
            rsp_valid  <= 1'b1;
            rsp_rdata  <= we_q ? '0 : extend({{WIDTH{1'b0}}, mem_rdata}, off_q, f3_q);
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_byteen <= 4'd0;
          end
        end
`ifdef LSU_MISALIGNED_EN
        BEAT1: begin
          state      <= RESP;
          rsp_valid  <= 1'b1;
          rsp_rdata  <= we_q ? '0 : extend({mem_rdata, lo_q}, off_q, f3_q);
          mem_read   <= 1'b0;
          mem_write  <= 1'b0;
          mem_addr   <= '0;
          mem_wdata  <= '0;
          mem_byteen <= 4'd0;
        end
`endif
        RESP: begin
          state          <= IDLE;
          rsp_rdata      <= '0;
          rsp_misaligned <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit: the initiator side of the data-memory port. Accepts one load or store per handshake from the core's memory stage and turns it into word-addressed `dmem` accesses with byte enables, lane-shifted store data and extended load data. A word-crossing access is split into two sequential beats. Sits between the pipeline MEM stage and `dmem`; `dmem` reads combinationally and writes on `posedge clk`.

## Interface
- `WIDTH`, 32, data/address width; memory word address is `WIDTH-2` bits
- `clk` in 1: clock
- `rst_n` in 1: synchronous active-low reset
- `req_valid` in 1: request present
- `req_ready` out 1: LSU can accept; high only in IDLE and only while `rst_n` is high
- `req_we` in 1: 1 = store, 0 = load
- `req_funct3` in 3: `[1:0]` size (00 byte, 01 half, 1x word); `[2]` = unsigned load (ignored for stores)
- `req_addr` in WIDTH: byte address
- `req_wdata` in WIDTH: store data, right-aligned
- `rsp_valid` out 1: one-cycle completion pulse (loads and stores)
- `rsp_rdata` out WIDTH: extended load data; 0 for stores and faults
- `rsp_misaligned` out 1: access rejected, valid with `rsp_valid`
- `mem_read`, `mem_write` out 1 each: dmem strobes
- `mem_addr` out WIDTH-2: word address
- `mem_wdata` out WIDTH: lane-aligned store data
- `mem_byteen` out 4: byte lane enables
- `mem_rdata` in WIDTH: dmem read word (combinational on `mem_addr`)

## Operation
- States: IDLE, BEAT0, BEAT1, RESP. Request registered on `req_valid && req_ready`; IDLE -> BEAT0.
- n = size in bytes (1/2/4), o = `req_addr[1:0]`, W = `req_addr[WIDTH-1:2]`. Crosses when o + n > 4.
- BEAT0: `mem_addr`=W, `mem_byteen`=((1<<n)-1)<<o truncated to 4 bits, `mem_wdata`=wdata<<8o; `mem_write`=we, `mem_read`=!we. Load word captured into lo register at the closing edge. Next: BEAT1 if crossing, else RESP.
- BEAT1: `mem_addr`=W+1 (modulo 2^(WIDTH-2), top word wraps to 0), `mem_byteen`=((1<<n)-1)>>(4-o), `mem_wdata`=wdata>>8(4-o). Next: RESP.
- Load assembly: {hi,lo} 64-bit >> 8o, keep low n bytes, sign-extend unless `funct3[2]`.
- RESP: `rsp_valid`=1 one cycle, no backpressure; -> IDLE.
- Outside BEAT0/BEAT1 all `mem_*` outputs are 0.

## Timing
- Reset (`rst_n` low at an edge): state IDLE; `rsp_valid`, `rsp_rdata`, `rsp_misaligned`, all `mem_*` = 0; `req_ready`=0 while `rst_n` low, 1 in the first cycle after release.
- Reset mid-operation: transaction aborted, no further beat issued, no `rsp_valid`; a BEAT0 store write already committed stays.
- Latency accept->`rsp_valid`: 2 cycles single-beat, 3 cycles two-beat, 1 cycle for a misaligned fault.
- One outstanding request; `req_ready` low from BEAT0 through RESP. Min accept spacing 3/4 cycles.
- Request inputs sampled only at acceptance; changes afterwards ignored.

## Configuration
- `LSU_MISALIGNED_EN` defined: any alignment supported as above; in-word misaligned access uses one beat, word-crossing uses two; `rsp_misaligned` always 0.
- Undefined: half with o[0]=1 or word with o!=0 is rejected: IDLE -> RESP directly, no `mem_*` strobe, `rsp_misaligned`=1, `rsp_rdata`=0. BEAT1 and crossing logic removed.

## Test plan
- Reset: hold `rst_n` low 2 cycles during a BEAT0 load -> all outputs 0, `req_ready`=0, no `rsp_valid`; after release `req_ready`=1.
- sw 0xDEADBEEF to 0x100, then lw 0x100 -> store beat `mem_addr`=0x40, byteen 1111; load `rsp_rdata`=0xDEADBEEF 2 cycles after accept.
- sb 0x80 to 0x103; lb 0x103 -> 0xFFFFFF80; lbu 0x103 -> 0x00000080; store beat byteen 1000, `mem_wdata`=0x80000000.
- Enabled: word at 0x100 = 0x44332211, 0x104 = 0x88776655; lw 0x102 -> beats addr 0x40 then 0x41, `rsp_rdata`=0x66554433, `rsp_valid` at cycle 3.
- Enabled: sh 0xABCD to 0x103 -> beat0 byteen 1000 data 0xCD000000, beat1 addr+1 byteen 0001 data 0x000000AB.
- Disabled: lh 0x101 -> no strobes, `rsp_misaligned`=1, `rsp_rdata`=0, `rsp_valid` 1 cycle after accept.
